// File: rtl/uart_rx_if.sv
// Receiver-to-consumer bundle for uart_rx_oversample.
//   user_rx_data   received word, LSB was first on the line
//   user_rx_valid  one-cycle pulse per completed frame
//   parity_err     parity status, meaningful with user_rx_valid
//   frame_err      stop-bit status, meaningful with user_rx_valid
//   busy           receiver is inside a frame
// The receiver drives the master modport; the consumer uses slave.
interface uart_rx_if #(
  parameter int P_DATA_WIDTH = 8
);
  logic [P_DATA_WIDTH-1:0] user_rx_data;
  logic                    user_rx_valid;
  logic                    parity_err;
  logic                    frame_err;
  logic                    busy;

  modport master (
    output user_rx_data,
    output user_rx_valid,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    input user_rx_data,
    input user_rx_valid,
    input parity_err,
    input frame_err,
    input busy
  );
endinterface

// File: rtl/uart_rx_oversample.sv
// 16x-oversampled UART receiver, single clock domain.
// The serial line is resynchronised, a falling edge in IDLE starts a frame,
// and every bit cell is sampled on ticks 7, 8 and 9 with a 2-of-3 vote.
// Each frame ends with a one-cycle valid pulse carrying data and status.
// Ports:
//   i_clk      system clock
//   i_rst      synchronous reset, active-high
//   i_uart_rx  asynchronous serial input, idle high
//   rx_if      uart_rx_if master: data, valid, parity_err, frame_err, busy
module uart_rx_oversample #(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BUADRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_uart_rx,
  uart_rx_if.master rx_if
);

  localparam int L_DIV_RAW = P_SYSTEM_CLK / (P_UART_BUADRATE * 16);
  localparam int L_DIV     = (L_DIV_RAW < 1) ? 1 : L_DIV_RAW;
  localparam int L_DIV_W   = (L_DIV > 1) ? $clog2(L_DIV) : 1;

  localparam logic [L_DIV_W-1:0] L_DIV_LAST  = L_DIV_W'(L_DIV - 1);
  localparam logic [3:0]         L_DATA_LAST = 4'(P_UART_DATA_WIDTH - 1);
  localparam logic [3:0]         L_STOP_LAST = 4'(P_UART_STOP_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state_reg, state_next;

  // [0],[1] form the synchroniser, [2] is the edge-detect history.
  logic [2:0] rx_pipe_reg;
  logic       rx_sync;
  logic       fall_edge;

  logic [L_DIV_W-1:0] div_cnt_reg;
  logic [3:0]         tick_cnt_reg;
  logic               tick;
  logic               tick_mid;
  logic               tick_end;
  logic               start_edge;

  logic [1:0] samp_reg;
  logic       maj;

  logic [3:0]                   bit_cnt_reg, bit_cnt_next;
  logic [P_UART_DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                         par_reg, par_next;
  logic                         ferr_reg, ferr_next;
  logic                         frame_done;
  logic                         parity_bad;

  logic [P_UART_DATA_WIDTH-1:0] data_reg;
  logic                         valid_reg;
  logic                         perr_out_reg;
  logic                         ferr_out_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_pipe_reg <= '1;
    end else begin
      rx_pipe_reg <= {rx_pipe_reg[1:0], i_uart_rx};
    end
  end

  assign rx_sync    = rx_pipe_reg[1];
  assign fall_edge  = rx_pipe_reg[2] & ~rx_sync;
  assign start_edge = (state_reg == S_IDLE) && fall_edge;

  // Divider and tick counter restart on the start edge so tick 0 of the
  // start cell is phase-locked to the detected edge.
  always_ff @(posedge i_clk) begin
    if (i_rst || start_edge) begin
      div_cnt_reg  <= '0;
      tick_cnt_reg <= '0;
    end else begin
      if (tick) begin
        div_cnt_reg  <= '0;
        tick_cnt_reg <= tick_cnt_reg + 4'd1;
      end else begin
        div_cnt_reg <= div_cnt_reg + L_DIV_W'(1);
      end
    end
  end

  assign tick     = (div_cnt_reg == L_DIV_LAST);
  assign tick_mid = tick && (tick_cnt_reg == 4'd9);
  assign tick_end = tick && (tick_cnt_reg == 4'd15);

  // Ticks 7 and 8 are stored; the tick-9 sample is voted in directly so the
  // decision is available in the tick-9 cycle itself.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      samp_reg <= '0;
    end else if (tick && (tick_cnt_reg == 4'd7 || tick_cnt_reg == 4'd8)) begin
      samp_reg <= {samp_reg[0], rx_sync};
    end
  end

  assign maj = (samp_reg[0] & samp_reg[1]) |
               (samp_reg[0] & rx_sync) |
               (samp_reg[1] & rx_sync);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= S_IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      par_reg     <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      par_reg     <= par_next;
      ferr_reg    <= ferr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    par_next     = par_reg;
    ferr_next    = ferr_reg;
    frame_done   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (fall_edge) begin
          state_next   = S_START;
          bit_cnt_next = '0;
          ferr_next    = 1'b0;
        end
      end
      S_START: begin
        if (tick_mid && maj) begin
          state_next = S_IDLE;  // start bit did not hold low: glitch
        end else if (tick_end) begin
          state_next   = S_DATA;
          bit_cnt_next = '0;
        end
      end
      S_DATA: begin
        if (tick_mid) begin
          shift_next = {maj, shift_reg[P_UART_DATA_WIDTH-1:1]};
        end
        if (tick_end) begin
          if (bit_cnt_reg == L_DATA_LAST) begin
            bit_cnt_next = '0;
            state_next   = (P_UART_CHECK != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick_mid) begin
          par_next = maj;
        end
        if (tick_end) begin
          state_next   = S_STOP;
          bit_cnt_next = '0;
        end
      end
      S_STOP: begin
        if (tick_mid) begin
          if (!maj) begin
            ferr_next = 1'b1;
          end
          // Leaving mid-cell lets a back-to-back start edge be seen.
          if (bit_cnt_reg == L_STOP_LAST) begin
            frame_done = 1'b1;
            state_next = S_IDLE;
          end
        end else if (tick_end) begin
          bit_cnt_next = bit_cnt_reg + 4'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign parity_bad = (P_UART_CHECK == 1) ? ~(^{shift_reg, par_reg}) :
                      (P_UART_CHECK == 2) ?  (^{shift_reg, par_reg}) : 1'b0;

  // The last stop vote is folded in here because ferr_reg only picks it up
  // on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_reg    <= 1'b0;
      data_reg     <= '0;
      perr_out_reg <= 1'b0;
      ferr_out_reg <= 1'b0;
    end else begin
      valid_reg <= frame_done;
      if (frame_done) begin
        data_reg     <= shift_reg;
        perr_out_reg <= parity_bad;
        ferr_out_reg <= ferr_reg | ~maj;
      end
    end
  end

  assign rx_if.user_rx_data  = data_reg;
  assign rx_if.user_rx_valid = valid_reg;
  assign rx_if.parity_err    = perr_out_reg;
  assign rx_if.frame_err     = ferr_out_reg;
  assign rx_if.busy          = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
`timescale 1ns/1ps
module tb_uart_rx_oversample;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line = 1'b1;
  logic sel = 1'b0;  // 0: drive the no-parity DUT, 1: the even-parity DUT
  logic rx_n, rx_e;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_start = 0;
  int t_valid_n = 0;
  int nvalid_n = 0;
  int nvalid_e = 0;
  int nv;
  logic [7:0] last_data_n = '0;
  logic prev_valid_n = 1'b0;
  logic prev_valid_e = 1'b0;
  exp_t hold_n = '0;
  exp_t hold_e = '0;
  exp_t q_n[$];
  exp_t q_e[$];

  uart_rx_if #(.P_DATA_WIDTH(8)) if_n ();
  uart_rx_if #(.P_DATA_WIDTH(8)) if_e ();

  assign rx_n = sel ? 1'b1 : line;
  assign rx_e = sel ? line : 1'b1;

  uart_rx_oversample #(
    .P_SYSTEM_CLK(3_200_000), .P_UART_BUADRATE(100_000), .P_UART_CHECK(0)
  ) dut_n (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_n), .rx_if(if_n.master)
  );

  uart_rx_oversample #(
    .P_SYSTEM_CLK(3_200_000), .P_UART_BUADRATE(100_000), .P_UART_CHECK(2)
  ) dut_e (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_e), .rx_if(if_e.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Expected frame outcome straight from the line bits that were sent.
  function automatic exp_t model_frame(input logic [7:0] d, input logic p, input logic stop, input int mode);
    exp_t r;
    logic odd_ones;
    odd_ones = (^d) ^ p;
    r.d  = d;
    r.fe = ~stop;
    r.pe = (mode == 1) ? (odd_ones != 1'b1) : (mode == 2) ? (odd_ones != 1'b0) : 1'b0;
    return r;
  endfunction

  // Bit k of 'bits' occupies clocks [k*num/den, (k+1)*num/den). A set noise
  // bit flips the line for one clock in the middle of that bit. From frame
  // bit rst_bit onward reset is held until the sequence ends.
  task automatic drive(input logic [31:0] bits, input int nbits, input int num, input int den,
                       input logic [31:0] noise, input int rst_bit);
    int total;
    int k;
    int bstart;
    int bend;
    logic v;
    total = (nbits * num) / den;
    k = 0;
    for (int c = 0; c < total; c++) begin
      while (k < nbits - 1 && c >= ((k + 1) * num) / den) k++;
      bstart = (k * num) / den;
      bend   = ((k + 1) * num) / den;
      v = bits[k];
      if (noise[k] && c == (bstart + bend) / 2) v = ~v;
      @(posedge clk); #1;
      if (c == 0) t_start = cyc;
      if (rst_bit >= 0 && k >= rst_bit) rst = 1'b1;
      line = v;
    end
    @(posedge clk); #1;
    line = 1'b1;
    rst  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && (q_n.size() != 0 || q_e.size() != 0); i++) @(posedge clk);
    chk(name, q_n.size() + q_e.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Scoreboard compare on every falling edge outside reset.
  always @(negedge clk) begin
    prev_valid_n <= if_n.user_rx_valid;
    prev_valid_e <= if_e.user_rx_valid;
    if (rst) begin
      hold_n <= '0;
      hold_e <= '0;
    end else begin
      if (if_n.user_rx_valid) begin
        nvalid_n <= nvalid_n + 1;
        t_valid_n <= cyc;
        last_data_n <= if_n.user_rx_data;
        $display("rx dut=n data=%02h perr=%0b ferr=%0b cyc=%0d", if_n.user_rx_data,
                 if_n.parity_err, if_n.frame_err, cyc);
        chk("valid_width_n", prev_valid_n, 0);
        if (q_n.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid_n actual=valid required=none");
        end else begin
          chk("data_n", if_n.user_rx_data, q_n[0].d);
          chk("perr_n", if_n.parity_err, q_n[0].pe);
          chk("ferr_n", if_n.frame_err, q_n[0].fe);
          hold_n <= q_n[0];
          void'(q_n.pop_front());
        end
      end else begin
        chk("hold_data_n", if_n.user_rx_data, hold_n.d);
        chk("hold_flags_n", {if_n.parity_err, if_n.frame_err}, {hold_n.pe, hold_n.fe});
      end
      if (if_e.user_rx_valid) begin
        nvalid_e <= nvalid_e + 1;
        $display("rx dut=e data=%02h perr=%0b ferr=%0b cyc=%0d", if_e.user_rx_data,
                 if_e.parity_err, if_e.frame_err, cyc);
        chk("valid_width_e", prev_valid_e, 0);
        if (q_e.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid_e actual=valid required=none");
        end else begin
          chk("data_e", if_e.user_rx_data, q_e[0].d);
          chk("perr_e", if_e.parity_err, q_e[0].pe);
          chk("ferr_e", if_e.frame_err, q_e[0].fe);
          hold_e <= q_e[0];
          void'(q_e.pop_front());
        end
      end else begin
        chk("hold_data_e", if_e.user_rx_data, hold_e.d);
        chk("hold_flags_e", {if_e.parity_err, if_e.frame_err}, {hold_e.pe, hold_e.fe});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_n", if_n.user_rx_valid, 0);
    chk("rst_data_n", if_n.user_rx_data, 0);
    chk("rst_flags_n", {if_n.parity_err, if_n.frame_err}, 0);
    chk("rst_busy_n", if_n.busy, 0);
    chk("rst_valid_e", if_e.user_rx_valid, 0);
    chk("rst_busy_e", if_e.busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(10);

    // 1: 0xA5, 8N1
    q_n.push_back(model_frame(8'hA5, 1'b0, 1'b1, 0));
    drive({22'h0, 1'b1, 8'hA5, 1'b0}, 10, 32, 1, 32'h0, -1);
    wait_drain("t1_drain");
    chk("t1_latency_in_window", ((t_valid_n - t_start) >= 300 && (t_valid_n - t_start) <= 330), 1);
    chk("t1_data_literal", last_data_n, 8'hA5);
    chk("t1_count", nvalid_n, 1);
    idle(40);

    // 2: even parity, good then bad parity bit
    sel = 1'b1;
    q_e.push_back(model_frame(8'h3C, 1'b0, 1'b1, 2));
    drive({21'h0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, 32, 1, 32'h0, -1);
    wait_drain("t2a_drain");
    chk("t2a_perr_literal", if_e.parity_err, 0);
    idle(40);
    q_e.push_back(model_frame(8'h3C, 1'b1, 1'b1, 2));
    drive({21'h0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11, 32, 1, 32'h0, -1);
    wait_drain("t2b_drain");
    chk("t2b_perr_literal", if_e.parity_err, 1);
    chk("t2b_data_literal", if_e.user_rx_data, 8'h3C);
    chk("t2_count_e", nvalid_e, 2);
    idle(40);
    sel = 1'b0;
    idle(5);

    // 3: 8-clock low glitch
    nv = nvalid_n;
    @(posedge clk); #1;
    line = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("t3_busy_high", if_n.busy, 1);
    @(posedge clk); #1;
    line = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("t3_busy_dropped", if_n.busy, 0);
    idle(100);
    chk("t3_no_valid", nvalid_n, nv);

    // 4: stop bit forced low, then a 3-frame break
    q_n.push_back(model_frame(8'h55, 1'b0, 1'b0, 0));
    drive({22'h0, 1'b0, 8'h55, 1'b0}, 10, 32, 1, 32'h0, -1);
    wait_drain("t4a_drain");
    chk("t4a_ferr_literal", if_n.frame_err, 1);
    chk("t4a_data_literal", if_n.user_rx_data, 8'h55);
    idle(40);
    nv = nvalid_n;
    q_n.push_back(model_frame(8'h00, 1'b0, 1'b0, 0));
    drive(32'h0, 30, 32, 1, 32'h0, -1);
    idle(100);
    wait_drain("t4b_drain");
    chk("t4b_one_valid", nvalid_n, nv + 1);
    chk("t4b_ferr_literal", if_n.frame_err, 1);
    idle(40);

    // 5: back-to-back at +2% baud with one-clock noise mid-bit
    nv = nvalid_n;
    q_n.push_back(model_frame(8'h01, 1'b0, 1'b1, 0));
    q_n.push_back(model_frame(8'hFE, 1'b0, 1'b1, 0));
    drive({12'h0, 1'b1, 8'hFE, 1'b0, 1'b1, 8'h01, 1'b0}, 20, 3200, 102, 32'h0007FDFF, -1);
    wait_drain("t5_drain");
    chk("t5_two_valids", nvalid_n, nv + 2);
    chk("t5_data_literal", last_data_n, 8'hFE);
    idle(40);

    // 6: reset at data bit 4, then a clean frame
    nv = nvalid_n;
    drive({22'h0, 1'b1, 8'h81, 1'b0}, 10, 32, 1, 32'h0, 5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_data_cleared", if_n.user_rx_data, 0);
    chk("t6_busy_cleared", if_n.busy, 0);
    chk("t6_no_valid", nvalid_n, nv);
    idle(40);
    q_n.push_back(model_frame(8'h81, 1'b0, 1'b1, 0));
    drive({22'h0, 1'b1, 8'h81, 1'b0}, 10, 32, 1, 32'h0, -1);
    wait_drain("t6_drain");
    chk("t6_data_literal", last_data_n, 8'h81);
    chk("t6_count", nvalid_n, nv + 1);
    idle(40);

    chk("final_pending", q_n.size() + q_e.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
